// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard unit: load-use stall, memory-wait hold, jump flush
// Counts stalled cycles and flags a data-memory wait that runs past MAX_MEM_WAIT.
module hazard_unit #(
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             mem_busy,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic             timeout_err
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] LDSTALL = 2'd1;
    localparam logic [1:0] MEMWAIT = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JUMP  = 6'b000010;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_NOP   = 6'b111100;

    localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MEM_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              uses_rs;
    logic              uses_rt;
    logic              lu_hz;
    logic              timeout_hit;

    always_comb begin
        uses_rs = (id_opcode != OP_JUMP) && (id_opcode != OP_NOP);
        uses_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW);
        lu_hz   = ex_memread && (ex_rt != 5'd0) &&
                  ((uses_rs && (ex_rt == id_rs)) || (uses_rt && (ex_rt == id_rt)));
    end

    // Memory busy always wins; a load-use hazard only matters in RUN because
    // by LDSTALL the load has already advanced to MEM.
    always_comb begin
        state_nxt = RUN;
        wait_nxt  = '0;
        stall     = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    stall     = 1'b1;
                    state_nxt = MEMWAIT;
                    wait_nxt  = WAIT_ONE;
                end else if (lu_hz) begin
                    stall     = 1'b1;
                    state_nxt = LDSTALL;
                end
            end
            LDSTALL: begin
                if (mem_busy) begin
                    stall     = 1'b1;
                    state_nxt = MEMWAIT;
                    wait_nxt  = WAIT_ONE;
                end
            end
            MEMWAIT: begin
                if (mem_busy) begin
                    stall     = 1'b1;
                    state_nxt = MEMWAIT;
                    wait_nxt  = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + WAIT_ONE;
                end
            end
            default: begin
                stall = mem_busy;
            end
        endcase
    end

    assign pc_write    = ~stall;
    assign ifid_write  = ~stall;
    assign ifid_flush  = (id_opcode == OP_JUMP) && !stall;
    assign timeout_hit = (state == MEMWAIT) && mem_busy && (wait_cnt == WAIT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (stall && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
